// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches 16-bit words over req/ack,
// hands each one to the control unit with a single run pulse, then advances or branches.
module fetch_unit #(
  parameter int unsigned          ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       instruction,
  output logic              run,
  input  logic              done,
  input  logic [2:0]        cmp_flags,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic [15:0]       retired_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    ISSUE     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_instr;
  logic [15:0]       r_retired;

  logic              w_is_branch;
  logic              w_taken;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (enable)  w_next = REQ;
      REQ:       if (mem_ack) w_next = ISSUE;
      ISSUE:     w_next = WAIT_DONE;
      WAIT_DONE: if (done)    w_next = enable ? REQ : IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // cmp_flags is {lt, gt, eq}
  always_comb begin
    w_taken = 1'b0;
    case (r_instr[3:2])
      2'b00:   w_taken = cmp_flags[0];
      2'b01:   w_taken = cmp_flags[1];
      2'b10:   w_taken = cmp_flags[2];
      default: w_taken = 1'b1;
    endcase
  end

  assign w_is_branch = (r_instr[1:0] == 2'b10);
  assign w_target    = ADDR_W'(r_instr[11:4]);
  assign w_pc_next   = (w_is_branch && w_taken) ? w_target : r_pc + ADDR_W'(1);
  assign w_retire    = (r_state == WAIT_DONE) && done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_retired <= '0;
    end else begin
      if (r_state == REQ && mem_ack) r_instr <= mem_rdata;
      if (w_retire) begin
        r_pc      <= w_pc_next;
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  assign mem_req       = (r_state == REQ);
  assign mem_addr      = (r_state == REQ) ? r_pc : '0;
  assign run           = (r_state == ISSUE);
  assign busy          = (r_state != IDLE);
  assign instruction   = r_instr;
  assign pc            = r_pc;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-computed PC/instruction/count values per step.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] instruction;
  logic        run;
  logic        done = 1'b0;
  logic [2:0]  cmp_flags = '0;
  logic [7:0]  pc;
  logic        busy;
  logic [15:0] retired_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instruction(instruction), .run(run), .done(done), .cmp_flags(cmp_flags),
    .pc(pc), .busy(busy), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the DUT in REQ; returns at the negedge after done.
  task automatic run_instr(input logic [15:0] rdata, input logic [2:0] flags,
                           input int unsigned dly, input bit drop_en);
    chk("req_before_ack", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    mem_rdata = rdata;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 16'hDEAD;
    chk("run_pulse", {31'd0, run}, 32'd1);
    chk("instr_latched", {16'd0, instruction}, {16'd0, rdata});
    @(posedge clk); @(negedge clk);
    chk("run_single", {31'd0, run}, 32'd0);
    for (int unsigned i = 0; i < dly; i++) begin
      @(posedge clk); @(negedge clk);
    end
    if (drop_en) enable = 1'b0;
    done = 1'b1;
    cmp_flags = flags;
    @(posedge clk); @(negedge clk);
    done = 1'b0;
    cmp_flags = '0;
    chk("instr_hold", {16'd0, instruction}, {16'd0, rdata});
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_pc", {24'd0, pc}, 32'h0);
    chk("rst_instr", {16'd0, instruction}, 32'h0);
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", {24'd0, mem_addr}, 32'h0);
    chk("rst_cnt", {16'd0, retired_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;
    @(posedge clk); @(negedge clk);

    // first fetch, zero-wait ack, done three cycles after run
    chk("t1_addr", {24'd0, mem_addr}, 32'h0);
    run_instr(16'h2001, 3'b000, 2, 1'b0);
    chk("t1_pc", {24'd0, pc}, 32'h1);
    chk("t1_cnt", {16'd0, retired_count}, 32'd1);
    chk("t1_next_req", {31'd0, mem_req}, 32'd1);
    chk("t1_next_addr", {24'd0, mem_addr}, 32'h1);

    // ack held off for four cycles
    for (int unsigned i = 0; i < 4; i++) begin
      chk("t2_req_hold", {31'd0, mem_req}, 32'd1);
      chk("t2_addr_hold", {24'd0, mem_addr}, 32'h1);
      chk("t2_no_run", {31'd0, run}, 32'd0);
      chk("t2_instr_old", {16'd0, instruction}, 32'h2001);
      @(posedge clk); @(negedge clk);
    end
    run_instr(16'h1234, 3'b000, 0, 1'b0);
    chk("t2_pc", {24'd0, pc}, 32'h2);

    // branches: always to 5, then always to A0, eq-conditional both ways
    run_instr(16'h005E, 3'b000, 0, 1'b0);
    chk("br_to5", {24'd0, pc}, 32'h5);
    run_instr(16'h0A0E, 3'b000, 1, 1'b0);
    chk("br_always", {24'd0, pc}, 32'hA0);
    run_instr(16'h005E, 3'b000, 0, 1'b0);
    run_instr(16'h0A02, 3'b110, 0, 1'b0);
    chk("br_eq_not", {24'd0, pc}, 32'h6);
    run_instr(16'h005E, 3'b000, 0, 1'b0);
    run_instr(16'h0A02, 3'b001, 0, 1'b0);
    chk("br_eq_taken", {24'd0, pc}, 32'hA0);
    run_instr(16'h0FF6, 3'b010, 0, 1'b0);
    chk("br_gt_taken", {24'd0, pc}, 32'hFF);

    // wrap from FF
    run_instr(16'h1234, 3'b000, 0, 1'b0);
    chk("wrap_pc", {24'd0, pc}, 32'h0);
    chk("wrap_addr", {24'd0, mem_addr}, 32'h0);
    chk("cnt_10", {16'd0, retired_count}, 32'd10);

    // lt condition, not taken then taken
    run_instr(16'h0FFA, 3'b010, 0, 1'b0);
    chk("br_lt_not", {24'd0, pc}, 32'h1);
    run_instr(16'h0FFA, 3'b100, 0, 1'b0);
    chk("br_lt_taken", {24'd0, pc}, 32'hFF);

    // enable dropped during WAIT_DONE
    run_instr(16'h0001, 3'b000, 1, 1'b1);
    chk("drop_pc", {24'd0, pc}, 32'h0);
    chk("drop_cnt", {16'd0, retired_count}, 32'd13);
    chk("drop_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("drop_req", {31'd0, mem_req}, 32'd0);
    chk("drop_busy2", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("resume_req", {31'd0, mem_req}, 32'd1);
    chk("resume_addr", {24'd0, mem_addr}, 32'h0);

    // asynchronous reset during REQ
    run_instr(16'h033E, 3'b000, 0, 1'b0);
    chk("pre_rst_addr", {24'd0, mem_addr}, 32'h33);
    #1 reset = 1'b0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_addr", {24'd0, mem_addr}, 32'h0);
    chk("arst_pc", {24'd0, pc}, 32'h0);
    chk("arst_instr", {16'd0, instruction}, 32'h0);
    chk("arst_cnt", {16'd0, retired_count}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 16'hFFFF;
    done = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("late_instr", {16'd0, instruction}, 32'h0);
    chk("late_pc", {24'd0, pc}, 32'h0);
    chk("late_cnt", {16'd0, retired_count}, 32'd0);
    chk("late_run", {31'd0, run}, 32'd0);
    mem_ack = 1'b0;
    done = 1'b0;

    // asynchronous reset during WAIT_DONE
    enable = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 16'h4440;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("wd_busy", {31'd0, busy}, 32'd1);
    chk("wd_instr", {16'd0, instruction}, 32'h4440);
    #1 reset = 1'b0;
    #1;
    chk("arst2_busy", {31'd0, busy}, 32'd0);
    chk("arst2_instr", {16'd0, instruction}, 32'h0);
    chk("arst2_run", {31'd0, run}, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    done = 1'b1;
    @(posedge clk); @(negedge clk);
    done = 1'b0;
    chk("late_done_cnt", {16'd0, retired_count}, 32'd0);
    chk("late_done_pc", {24'd0, pc}, 32'h0);
    chk("late_done_req", {31'd0, mem_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the processor control unit.
- Holds the program counter and reads 16-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction stably to the control unit and pulses run for exactly one cycle.
- Waits for the control unit's done, then advances the PC sequentially or takes a branch (format 2'b10) using the ALU compare flags.

Parameters:
ADDR_W, 8, width of program counter and instruction memory address
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset
enable  input  1  1 = fetch and execute continuously; 0 = stop at next instruction boundary
mem_req  output  1  instruction memory read request
mem_addr  output  ADDR_W  read address, equals pc while mem_req=1
mem_ack  input  1  memory response; mem_rdata valid in same cycle
mem_rdata  input  16  instruction word from memory
instruction  output  16  registered instruction to control unit
run  output  1  one-cycle start pulse to control unit
done  input  1  control unit has completed the current instruction
cmp_flags  input  3  {lt, gt, eq} from ALU compare result
pc  output  ADDR_W  current program counter
busy  output  1  high in any state other than IDLE
retired_count  output  16  number of completed instructions, wraps at 16'hFFFF->0

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pc=RESET_PC, instruction=0, run=0, mem_req=0, mem_addr=0, retired_count=0, busy=0. Takes effect immediately, including mid-fetch or mid-execute. Pending memory response is discarded.
- States: IDLE, REQ, ISSUE, WAIT_DONE.
- IDLE: all outputs inactive. If enable=1, go to REQ on next edge.
- REQ: mem_req=1, mem_addr=pc.
  - mem_ack=1: latch mem_rdata into instruction, go to ISSUE.
  - mem_ack=0: stay in REQ, holding req and addr stable.
  - enable is not sampled in REQ; an accepted fetch always executes.
- ISSUE: run=1 for this single cycle; go to WAIT_DONE. instruction is held stable from the ISSUE cycle until the cycle after done.
- WAIT_DONE: run=0. On done=1:
  - retired_count increments.
  - pc is updated per the next-PC rule.
  - Go to REQ if enable=1, else IDLE.
  - done=1 is ignored in every other state.
- Next-PC rule, evaluated in the done cycle using cmp_flags sampled in that cycle:
  - instruction[1:0] != 2'b10: pc = pc+1.
  - instruction[1:0] == 2'b10 (branch): cond = instruction[3:2]. Taken when:
    - 00: eq=1
    - 01: gt=1
    - 10: lt=1
    - 11: always
  - Taken branch: pc = instruction[11:4] zero-extended or truncated to ADDR_W. Not taken: pc = pc+1.
- PC arithmetic is modulo 2^ADDR_W; pc=all-ones increments to 0.
- mem_ack outside REQ is ignored.
- Best-case cycles per instruction: REQ(1) + ISSUE(1) + control-unit latency until done, plus 1 cycle for the done cycle.
- enable drop: the current instruction completes (including its PC update), then the block parks in IDLE with pc pointing at the next instruction. Re-asserting enable resumes from that pc.
- run never asserts twice without an intervening done.

Test Plan:
- Reset then enable=1, memory acks in the same cycle with mem_rdata=16'h2001 at addr 0, done returned 3 cycles after run -> mem_addr=0, run pulses once one cycle after ack, instruction=16'h2001, pc=1 after done, retired_count=1, next mem_req addr=1.
- Memory ack delayed 4 cycles -> mem_req and mem_addr held stable for 4 cycles, no run until the ack cycle +1, instruction updates only on ack.
- Branch 16'h0A0E (format 10, cond 11, target 8'hA0) at pc=5 -> pc=8'hA0 after done. Repeat with cond 00 (16'h0A02): eq=0 -> pc=6; eq=1 -> pc=8'hA0.
- pc=8'hFF, non-branch instruction completes -> pc wraps to 0, next mem_addr=0.
- enable deasserted while in WAIT_DONE -> done still increments pc and retired_count, state IDLE, busy=0, mem_req stays 0. Re-enable -> fetch resumes at the new pc.
- reset asserted during REQ and during WAIT_DONE -> outputs go to reset values asynchronously (before the next clock edge), pc=RESET_PC. A late mem_ack or done after reset release, while in IDLE, has no effect.
